// File: rtl/sfx_arbiter.sv
// Sound-effect arbiter: latches request pulses, grants the tone channel by
// fixed priority (bit 0 highest), plays each effect for DUR frames.
// Ports: system_clk_25MHz, rst_n (async low), frame_end, sfx_req[3:0],
//        sfx_mute -> tone_period[7:0], tone_en, active_id[1:0], busy,
//        pending[3:0]. All outputs are registered.
module sfx_arbiter #(
   parameter logic [7:0] TONE_0 = 8'd40,
   parameter logic [7:0] TONE_1 = 8'd20,
   parameter logic [7:0] TONE_2 = 8'd60,
   parameter logic [7:0] TONE_3 = 8'd90,
   parameter logic [3:0] DUR_0  = 4'd8,
   parameter logic [3:0] DUR_1  = 4'd4,
   parameter logic [3:0] DUR_2  = 4'd6,
   parameter logic [3:0] DUR_3  = 4'd2
) (
   input  logic       system_clk_25MHz,
   input  logic       rst_n,
   input  logic       frame_end,
   input  logic [3:0] sfx_req,
   input  logic       sfx_mute,
   output logic [7:0] tone_period,
   output logic       tone_en,
   output logic [1:0] active_id,
   output logic       busy,
   output logic [3:0] pending
);

   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] pend_q, pend_d;
   logic [7:0] per_q, per_d;
   logic       en_q, en_d;
   logic [1:0] id_q, id_d;
   logic       busy_q, busy_d;

   logic [3:0] lowbit;
   logic [3:0] below;
   logic [3:0] id_oh;
   logic [3:0] req_q;
   logic [3:0] gmask;
   logic [1:0] k;
   logic       preempt;
   logic       grant;
   logic       retrig;

   function automatic logic [3:0] dur_of(input logic [1:0] i);
      logic [3:0] d;
      unique case (i)
         2'd0: d = DUR_0;
         2'd1: d = DUR_1;
         2'd2: d = DUR_2;
         default: d = DUR_3;
      endcase
      // A zero duration still plays for one frame.
      return (d == 4'd0) ? 4'd1 : d;
   endfunction

   function automatic logic [7:0] tone_of(input logic [1:0] i);
      logic [7:0] t;
      unique case (i)
         2'd0: t = TONE_0;
         2'd1: t = TONE_1;
         2'd2: t = TONE_2;
         default: t = TONE_3;
      endcase
      return t;
   endfunction

   // Isolate lowest set pending bit, so the decoder below is one-hot.
   assign lowbit = pend_q & (~pend_q + 4'd1);

   always_comb begin
      k = 2'd0;
      unique case (1'b1)
         lowbit[0]: k = 2'd0;
         lowbit[1]: k = 2'd1;
         lowbit[2]: k = 2'd2;
         lowbit[3]: k = 2'd3;
         default:   k = 2'd0;
      endcase
   end

   always_comb begin
      below = 4'b0000;
      unique case (id_q)
         2'd0: below = 4'b0000;
         2'd1: below = 4'b0001;
         2'd2: below = 4'b0011;
         default: below = 4'b0111;
      endcase
   end

   assign id_oh   = 4'b0001 << id_q;
   assign preempt = (state_q == PLAY) && |(pend_q & below);
   assign grant   = ((state_q == IDLE) && |pend_q) || preempt;
   assign gmask   = grant ? lowbit : 4'b0000;
   // A request for the playing id retriggers instead of queueing.
   assign req_q   = (state_q == PLAY) ? (sfx_req & ~id_oh) : sfx_req;
   assign retrig  = (state_q == PLAY) && |(sfx_req & id_oh);
   assign pend_d  = (pend_q | req_q) & ~gmask;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      id_d    = id_q;
      per_d   = per_q;
      unique case (state_q)
         IDLE: begin
            if (grant) begin
               state_d = PLAY;
               cnt_d   = dur_of(k);
               id_d    = k;
               per_d   = tone_of(k);
            end
         end
         PLAY: begin
            // Preemption load overrides any frame decrement.
            if (preempt) begin
               cnt_d = dur_of(k);
               id_d  = k;
               per_d = tone_of(k);
            end else if (retrig) begin
               cnt_d = dur_of(id_q);
            end else if (frame_end) begin
               if (cnt_q <= 4'd1) begin
                  state_d = GAP;
                  cnt_d   = 4'd0;
                  id_d    = 2'd0;
                  per_d   = 8'd0;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         default: begin
            if (frame_end) state_d = IDLE;
         end
      endcase
      en_d   = (state_d == PLAY) && !sfx_mute;
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge system_clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         pend_q  <= 4'd0;
         per_q   <= 8'd0;
         en_q    <= 1'b0;
         id_q    <= 2'd0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         per_q   <= per_d;
         en_q    <= en_d;
         id_q    <= id_d;
         busy_q  <= busy_d;
      end
   end

   assign tone_period = per_q;
   assign tone_en     = en_q;
   assign active_id   = id_q;
   assign busy        = busy_q;
   assign pending     = pend_q;

endmodule

// File: doc/sfx_arbiter.md
# sfx_arbiter

Shares the single tone channel of the audio processing unit between the game's sound-effect sources: player hurt, sword hit on the dragon, dragon eats sheep, and player attack. It latches one-cycle request pulses, grants the channel by fixed priority, and plays each effect for a set number of video frames. Frames are counted with the sync generator's `frame_end`. A higher-priority effect preempts a lower one. The block outputs the tone half-period and enable that the audio unit uses to drive `sound`.

## Interface
- `TONE_0`, default 8'd40, half-period code for request 0 (player hurt)
- `TONE_1`, default 8'd20, half-period code for request 1 (sword hits dragon)
- `TONE_2`, default 8'd60, half-period code for request 2 (dragon eats sheep)
- `TONE_3`, default 8'd90, half-period code for request 3 (attack swing)
- `DUR_0..DUR_3`, default 4'd8 / 4'd4 / 4'd6 / 4'd2, effect length in frames; a value of 0 is treated as 1
- `system_clk_25MHz`, in, 1, system clock
- `rst_n`, in, 1, reset: one clock, asynchronous, active-low
- `frame_end`, in, 1, one-cycle pulse per frame from the sync generator
- `sfx_req`, in, 4, one-cycle request pulses; bit 0 is the highest priority
- `sfx_mute`, in, 1, level signal; forces `tone_en` low, sequencing continues
- `tone_period`, out, 8, half-period code of the active effect; 0 when not in PLAY
- `tone_en`, out, 1, tone channel enable
- `active_id`, out, 2, index of the playing effect; 0 when not in PLAY
- `busy`, out, 1, high in PLAY or GAP
- `pending`, out, 4, latched requests not yet granted

## Operation
- **Reset state** (async, `rst_n`=0):
  - state=IDLE.
  - `pending`=0, `tone_period`=0, `tone_en`=0, `active_id`=0, `busy`=0.
  - Frame counter=0.
- **Pending register:** `pending_next = (pending | sfx_req) & ~grant_mask`.
  - A request in the same cycle as the grant of that bit is absorbed and does not queue.
  - Exception: a request for the currently playing id is not queued. It reloads the frame counter with that id's DUR (retrigger).
- **IDLE:**
  - If `pending` is nonzero, grant the lowest set index k.
  - Load counter with DUR_k, set `active_id`=k and `tone_period`=TONE_k, clear `pending[k]`, go to PLAY.
  - Otherwise stay in IDLE.
- **PLAY:**
  - `tone_en` = ~`sfx_mute`.
  - On `frame_end`, decrement the counter. If it was 1, go to GAP.
  - Preemption: if `pending` holds any index below `active_id`, grant it at once (same actions as IDLE, no GAP). The preempted effect is dropped, not re-queued.
  - A pending index at or above `active_id` waits.
- **GAP:**
  - `tone_en`=0, `tone_period`=0, `busy`=1.
  - Stay until the next `frame_end`, then go to IDLE. This gives one silent frame between consecutive effects.
  - Requests still latch during GAP. No grant and no preemption happen in GAP.
- **Same-cycle events:** `frame_end` and a preemption in the same cycle: preemption wins and the new counter load ignores the decrement.
- **Counter:** 4-bit; never decrements below 1 while in PLAY.

## Timing
- All outputs are registered.
- Request pulse at edge t: `pending` bit visible after edge t+1.
- From IDLE with the bit pending after t+1: grant at edge t+2, so `tone_en`/`tone_period` are valid 2 cycles after the request edge.
- PLAY length: exactly DUR_k `frame_end` pulses after the grant. GAP ends on the following `frame_end`.
- Preemption: new `tone_period` appears 1 cycle after the higher `pending` bit is visible.
- Mute: `tone_en` follows `sfx_mute` with 1-cycle latency.
- Reset asserted mid-PLAY: all outputs go to reset values immediately (async). Resume in IDLE on the first edge after release.

## Test plan
- Reset, then `sfx_req`=4'b0100 for 1 cycle: `pending`=4'b0100 one cycle later, then `tone_period`=60, `active_id`=2, `tone_en`=1. After 6 `frame_end` pulses go to GAP (`tone_en`=0, `busy`=1). After 1 more `frame_end`: IDLE, `busy`=0.
- Play id 3 (DUR 2), pulse `sfx_req[0]` during frame 1: switch to `tone_period`=40, `active_id`=0 without GAP. Id 3 is not replayed. Id 0 plays for 8 frames.
- Simultaneous `sfx_req`=4'b1010 in IDLE: id 1 plays 4 frames, then 1 GAP frame, then id 3 plays 2 frames. `pending`=4'b1000 during id 1.
- Id 1 playing with counter=1, re-pulse `sfx_req[1]`: counter reloads to 4, so 4 more frames before GAP. `pending` stays 0.
- `sfx_mute`=1 during id 2: `tone_en`=0 but `tone_period`=60 and `busy`=1. The GAP transition still occurs after 6 frames.
- Assert `rst_n`=0 mid-PLAY between clock edges: outputs go to 0 immediately, `pending`=0. After release with no requests, stay in IDLE.
